// File: rtl/t02_writeback_unit_pkg.sv
// Shared types for the writeback stage: FSM state encoding and load-type funct3 codes.
package t02_wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/t02_writeback_unit_if.sv
// Data-memory read port between the writeback stage (master) and data memory (slave).
interface t02_writeback_unit_if;

    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_read,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_read,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/t02_writeback_unit_load_extend.sv
// Combinational load formatter: selects the byte/half addressed by the low EA bits
// from the returned word and sign- or zero-extends it according to funct3.
module t02_load_extend
    import t02_wb_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (off_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // Reserved encodings fall through to a full-word load
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  result_o = {24'b0, byte_v};
            F3_LH:   result_o = {{16{half_v[15]}}, half_v};
            F3_LHU:  result_o = {16'b0, half_v};
            F3_LW:   result_o = rdata_i;
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/t02_writeback_unit.sv
// Writeback stage feeding the register file: ALU ops retire in one cycle, loads run a
// req/ack handshake with stall. Optional load timeout enabled by macro T02_WB_TIMEOUT_EN.
module t02_writeback_unit
    import t02_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
)
(
    input  logic        clk,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_alu_result,
    input  logic [2:0]  ex_funct3,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        reg_write,
    output logic [4:0]  write_index,
    output logic [31:0] write_data,
    output logic        load_fault
);

    wb_state_t   state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        intent_q, intent_d;
    logic        mem_read_q, mem_read_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_index_q, write_index_d;
    logic [31:0] write_data_q, write_data_d;

    logic        accept_alu, accept_load, timeout;
    logic [31:0] ext_data;

    // New instructions are taken in IDLE and in WRITE; WAIT_ACK ignores execute
    assign accept_alu  = (state_q != WAIT_ACK) && ex_valid && !ex_is_load;
    assign accept_load = (state_q != WAIT_ACK) && ex_valid && ex_is_load;

    t02_load_extend u_extend (
        .rdata_i  (mem_rdata),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .result_o (ext_data)
    );

`ifdef T02_WB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_fault_q;

    assign timeout = (state_q == WAIT_ACK) && !mem_ack &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept_load)
            cnt_d = '0;
        else if (state_q == WAIT_ACK && !mem_ack)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_q        <= '0;
            load_fault_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            load_fault_q <= timeout;
        end
    end

    assign load_fault = load_fault_q;
`else
    assign timeout    = 1'b0;
    assign load_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WRITE: state_d = accept_load ? WAIT_ACK : IDLE;
            WAIT_ACK:    if (mem_ack || timeout) state_d = WRITE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        stall         = 1'b0;
        rd_d          = rd_q;
        off_d         = off_q;
        funct3_d      = funct3_q;
        intent_d      = intent_q;
        mem_read_d    = mem_read_q;
        mem_addr_d    = mem_addr_q;
        reg_write_d   = 1'b0;
        write_index_d = write_index_q;
        write_data_d  = write_data_q;

        if (accept_alu) begin
            reg_write_d   = ex_reg_write && (ex_rd != 5'd0);
            write_index_d = ex_rd;
            write_data_d  = ex_alu_result;
        end

        if (accept_load) begin
            stall      = 1'b1;
            rd_d       = ex_rd;
            off_d      = ex_alu_result[1:0];
            funct3_d   = ex_funct3;
            intent_d   = ex_reg_write;
            mem_read_d = 1'b1;
            mem_addr_d = {ex_alu_result[31:2], 2'b00};
        end

        // An ack arriving on the expiry cycle takes priority over the timeout
        if (state_q == WAIT_ACK) begin
            stall = 1'b1;
            if (mem_ack || timeout) begin
                mem_read_d    = 1'b0;
                reg_write_d   = intent_q && (rd_q != 5'd0);
                write_index_d = rd_q;
                write_data_d  = mem_ack ? ext_data : 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rd_q          <= '0;
            off_q         <= '0;
            funct3_q      <= '0;
            intent_q      <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_addr_q    <= '0;
            reg_write_q   <= 1'b0;
            write_index_q <= '0;
            write_data_q  <= '0;
        end else begin
            rd_q          <= rd_d;
            off_q         <= off_d;
            funct3_q      <= funct3_d;
            intent_q      <= intent_d;
            mem_read_q    <= mem_read_d;
            mem_addr_q    <= mem_addr_d;
            reg_write_q   <= reg_write_d;
            write_index_q <= write_index_d;
            write_data_q  <= write_data_d;
        end
    end

    assign reg_write   = reg_write_q;
    assign write_index = write_index_q;
    assign write_data  = write_data_q;
    assign mem_read    = mem_read_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_t02_writeback_unit.sv
// Randomized self-checking bench for t02_writeback_unit against an arithmetic load model;
// the timeout scenario is compiled only when T02_WB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_t02_writeback_unit;

    logic        clk = 1'b0;
    logic        nRST;
    logic        ex_valid, ex_is_load, ex_reg_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result;
    logic [2:0]  ex_funct3;
    logic        stall, reg_write, load_fault;
    logic [4:0]  write_index;
    logic [31:0] write_data;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    t02_writeback_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk           (clk),
        .nRST          (nRST),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .ex_alu_result (ex_alu_result),
        .ex_funct3     (ex_funct3),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .stall         (stall),
        .reg_write     (reg_write),
        .write_index   (write_index),
        .write_data    (write_data),
        .load_fault    (load_fault)
    );

    always #5 clk = ~clk;

    // Reference load result: shift the addressed field down, mask, then sign-fix arithmetically
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] ea,
                                             input logic [2:0] f3);
        logic [31:0] w;
        case (f3)
            3'b000: begin
                w = (rdata >> (ea[1:0] * 8)) & 32'hFF;
                if (w >= 32'h80) w = w - 32'h100;
            end
            3'b100: w = (rdata >> (ea[1:0] * 8)) & 32'hFF;
            3'b001: begin
                w = (rdata >> (ea[1] ? 16 : 0)) & 32'hFFFF;
                if (w >= 32'h8000) w = w - 32'h10000;
            end
            3'b101: w = (rdata >> (ea[1] ? 16 : 0)) & 32'hFFFF;
            default: w = rdata;
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        ex_is_load    = 1'b0;
        ex_reg_write  = 1'b0;
        ex_rd         = 5'd0;
        ex_alu_result = 32'd0;
        ex_funct3     = 3'd0;
        mem_ack       = 1'b0;
        mem_rdata     = 32'd0;
    endtask

    // Presents one ALU op in the current cycle, checks its retire and the pulse width
    task automatic run_alu(input logic [4:0] rd, input logic [31:0] res, input logic we,
                           input string tag);
        logic exp_we;
        exp_we        = we && (rd != 5'd0);
        ex_valid      = 1'b1;
        ex_is_load    = 1'b0;
        ex_reg_write  = we;
        ex_rd         = rd;
        ex_alu_result = res;
        ex_funct3     = 3'($urandom_range(0, 7));
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s alu_stall: got %b expected 0", tag, stall);
        end
        tick();
        ex_valid = 1'b0;
        checks++;
        if (reg_write !== exp_we) begin
            errors++;
            $display("[TB] FAIL %s alu_reg_write: got %b expected %b", tag, reg_write, exp_we);
        end
        checks++;
        if (write_index !== rd || write_data !== res) begin
            errors++;
            $display("[TB] FAIL %s alu_data: got idx %0d data %h expected idx %0d data %h",
                     tag, write_index, write_data, rd, res);
        end
        tick();
        checks++;
        if (reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s alu_pulse: got %b expected 0", tag, reg_write);
        end
    endtask

    // Runs one load with `delay` ack-less WAIT_ACK cycles; returns with the stage in WRITE
    task automatic run_load(input logic [4:0] rd, input logic [31:0] ea, input logic [2:0] f3,
                            input logic [31:0] rdata, input logic we, input int delay,
                            input string tag);
        int          stall_cnt;
        logic        exp_we;
        logic [31:0] exp_addr, exp_data;
        stall_cnt     = 0;
        exp_we        = we && (rd != 5'd0);
        exp_addr      = ea & 32'hFFFF_FFFC;
        exp_data      = ref_load(rdata, ea, f3);
        ex_valid      = 1'b1;
        ex_is_load    = 1'b1;
        ex_reg_write  = we;
        ex_rd         = rd;
        ex_alu_result = ea;
        ex_funct3     = f3;
        #1;
        if (stall) stall_cnt++;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s load_accept_stall: got %b expected 1", tag, stall);
        end
        tick();
        ex_valid      = 1'b0;
        ex_alu_result = $urandom;
        for (int i = 0; i < delay; i++) begin
            if (stall) stall_cnt++;
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== exp_addr || reg_write !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s wait_bus: got read %b addr %h we %b expected 1 %h 0",
                         tag, mem_read, mem_addr, reg_write, exp_addr);
            end
            tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        #1;
        if (stall) stall_cnt++;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== exp_addr) begin
            errors++;
            $display("[TB] FAIL %s ack_bus: got read %b addr %h expected 1 %h",
                     tag, mem_read, mem_addr, exp_addr);
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        checks++;
        if (reg_write !== exp_we) begin
            errors++;
            $display("[TB] FAIL %s load_reg_write: got %b expected %b", tag, reg_write, exp_we);
        end
        checks++;
        if (write_data !== exp_data || write_index !== rd) begin
            errors++;
            $display("[TB] FAIL %s load_data: got idx %0d data %h expected idx %0d data %h",
                     tag, write_index, write_data, rd, exp_data);
        end
        checks++;
        if (mem_read !== 1'b0 || stall !== 1'b0 || load_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s load_done: got read %b stall %b fault %b expected 0 0 0",
                     tag, mem_read, stall, load_fault);
        end
        checks++;
        if (stall_cnt != delay + 2) begin
            errors++;
            $display("[TB] FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cnt, delay + 2);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        #3;
        checks++;
        if ({reg_write, stall, mem_read, load_fault} !== 4'b0 ||
            write_index !== 5'd0 || write_data !== 32'd0 || mem_addr !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got we %b stall %b rd %b flt %b idx %0d data %h addr %h expected all 0",
                     reg_write, stall, mem_read, load_fault, write_index, write_data, mem_addr);
        end
        @(negedge clk);
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_spec_vectors();
        run_alu(5'd5, 32'hDEADBEEF, 1'b1, "alu_deadbeef");
        run_load(5'd7, 32'h0000_1003, 3'b000, 32'h80FF_0000, 1'b1, 3, "lb");
        checks++;
        if (write_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("[TB] FAIL lb_const: got %h expected ffffff80", write_data);
        end
        tick();
        checks++;
        if (reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lb_pulse: got %b expected 0", reg_write);
        end
        run_load(5'd8, 32'h0000_2002, 3'b101, 32'h8001_1234, 1'b1, 1, "lhu");
        checks++;
        if (write_data !== 32'h0000_8001) begin
            errors++;
            $display("[TB] FAIL lhu_const: got %h expected 00008001", write_data);
        end
        tick();
        run_load(5'd9, 32'h0000_2002, 3'b001, 32'h8001_1234, 1'b1, 1, "lh");
        checks++;
        if (write_data !== 32'hFFFF_8001) begin
            errors++;
            $display("[TB] FAIL lh_const: got %h expected ffff8001", write_data);
        end
        tick();
    endtask

    task automatic test_rd_zero();
        run_load(5'd0, 32'h0000_3000, 3'b010, 32'h1234_5678, 1'b1, 2, "load_rd0");
        tick();
        run_alu(5'd0, 32'hCAFE_F00D, 1'b1, "alu_rd0");
        run_alu(5'd12, 32'h0BAD_0BAD, 1'b0, "alu_no_we");
    endtask

    task automatic test_back_to_back();
        run_load(5'd10, 32'h0000_4001, 3'b100, 32'hA5C3_7E81, 1'b1, 0, "b2b_load1");
        run_load(5'd11, 32'h0000_4006, 3'b011, 32'h7654_3210, 1'b1, 2, "b2b_load2");
        run_alu(5'd13, 32'h1357_9BDF, 1'b1, "b2b_alu");
    endtask

    task automatic test_spurious_ack();
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        tick();
        tick();
        mem_ack = 1'b0;
        checks++;
        if (reg_write !== 1'b0 || mem_read !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spurious_ack: got we %b read %b stall %b expected 0 0 0",
                     reg_write, mem_read, stall);
        end
    endtask

    task automatic test_reset_mid_load();
        ex_valid      = 1'b1;
        ex_is_load    = 1'b1;
        ex_reg_write  = 1'b1;
        ex_rd         = 5'd9;
        ex_alu_result = 32'h0000_5000;
        ex_funct3     = 3'b010;
        tick();
        ex_valid = 1'b0;
        tick();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || stall !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_load: got read %b stall %b we %b expected 0 0 0",
                     mem_read, stall, reg_write);
        end
        #2;
        nRST      = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (reg_write !== 1'b0 || mem_read !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_ack: got we %b read %b stall %b expected 0 0 0",
                     reg_write, mem_read, stall);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 1) == 1)
                run_load(rd, $urandom, 3'($urandom_range(0, 7)), $urandom, 1'($urandom),
                         $urandom_range(0, 3), "rand_load");
            else
                run_alu(rd, $urandom, 1'($urandom), "rand_alu");
        end
        tick();
    endtask

`ifdef T02_WB_TIMEOUT_EN
    task automatic test_timeout();
        ex_valid      = 1'b1;
        ex_is_load    = 1'b1;
        ex_reg_write  = 1'b1;
        ex_rd         = 5'd3;
        ex_alu_result = 32'h0000_6004;
        ex_funct3     = 3'b010;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_read !== 1'b1 || load_fault !== 1'b0 || stall !== 1'b1) begin
                errors++;
                $display("[TB] FAIL timeout_wait: got read %b fault %b stall %b expected 1 0 1",
                         mem_read, load_fault, stall);
            end
            tick();
        end
        checks++;
        if (load_fault !== 1'b1 || write_data !== 32'd0 || reg_write !== 1'b1 ||
            write_index !== 5'd3 || mem_read !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_expire: got fault %b data %h we %b idx %0d read %b stall %b expected 1 0 1 3 0 0",
                     load_fault, write_data, reg_write, write_index, mem_read, stall);
        end
        tick();
        checks++;
        if (load_fault !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: got fault %b we %b expected 0 0", load_fault, reg_write);
        end
        run_load(5'd4, 32'h0000_6001, 3'b000, 32'h0000_7F00, 1'b1, 3, "ack_on_expiry");
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_spec_vectors();
        test_rd_zero();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid_load();
        test_random();
`ifdef T02_WB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
